// File: rtl/mycpu_pkg.sv
// Shared mycpu types: program-counter operation encoding used by the fetch stage.
package mycpu_pkg;

  localparam int PC_OP_W = 3;

  typedef enum logic [PC_OP_W-1:0] {
    PC_HOLD = 3'd0,
    PC_INC  = 3'd1,
    PC_REL  = 3'd2,
    PC_ABS  = 3'd3,
    PC_CALL = 3'd4,
    PC_RET  = 3'd5
  } pc_op_t;

endpackage

// File: rtl/pc_ras_stack.sv
// Return-address stack for pc_ras. Saturating LIFO by default; define
// PC_RAS_WRAP_EN for a circular stack that overwrites its oldest entry when full.
module pc_ras_stack #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [W-1:0]                 push_data,
  output logic [W-1:0]                 pop_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         drop
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] IDX_ONE  = 1;
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] w_wr_idx;
  logic [AW-1:0] w_rd_idx;
  logic          w_full;
  logic          w_do_push;
  logic          w_do_pop;

`ifdef PC_RAS_WRAP_EN
  // Pointers carry one extra bit so head - tail spans 0..DEPTH without ambiguity.
  logic [AW:0] r_head;
  logic [AW:0] r_tail;
  logic [AW:0] w_count;

  assign w_count   = r_head - r_tail;
  assign w_full    = (w_count == FULL_CNT);
  assign empty     = (r_head == r_tail);
  assign w_wr_idx  = r_head[AW-1:0];
  assign w_rd_idx  = r_head[AW-1:0] - IDX_ONE;
  assign w_do_push = push;
  assign w_do_pop  = pop & ~empty;
  assign drop      = 1'b0;
  assign count     = w_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head <= '0;
      r_tail <= '0;
    end else if (w_do_push) begin
      r_head <= r_head + CNT_ONE;
      if (w_full) begin
        r_tail <= r_tail + CNT_ONE;
      end
    end else if (w_do_pop) begin
      r_head <= r_head - CNT_ONE;
    end
  end
`else
  logic [AW:0] r_depth;

  assign w_full    = (r_depth == FULL_CNT);
  assign empty     = (r_depth == '0);
  assign w_wr_idx  = r_depth[AW-1:0];
  assign w_rd_idx  = r_depth[AW-1:0] - IDX_ONE;
  assign w_do_push = push & ~w_full;
  assign w_do_pop  = pop & ~empty;
  assign drop      = push & w_full;
  assign count     = r_depth;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_depth <= '0;
    end else if (w_do_push) begin
      r_depth <= r_depth + CNT_ONE;
    end else if (w_do_pop) begin
      r_depth <= r_depth - CNT_ONE;
    end
  end
`endif

  // Entry contents need no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (w_do_push && !rst) begin
      r_mem[w_wr_idx] <= push_data;
    end
  end

  assign pop_data = r_mem[w_rd_idx];

endmodule

// File: rtl/pc_ras.sv
// Fetch-stage program counter with call/return stack and sticky overflow/underflow
// flags. Optional circular stack behaviour is selected with PC_RAS_WRAP_EN.
module pc_ras
  import mycpu_pkg::*;
#(
  parameter int           W         = 16,
  parameter int           DEPTH     = 4,
  parameter logic [W-1:0] RESET_VEC = '0,
  parameter int           INC_STEP  = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [PC_OP_W-1:0]           op_in,
  input  logic [W-1:0]                 ia_in,
  input  logic [W-1:0]                 ra_in,
  output logic [W-1:0]                 pc_out,
  output logic [$clog2(DEPTH+1)-1:0]   depth_out,
  output logic                         ovf_out,
  output logic                         unf_out
);

  localparam logic [W-1:0] STEP = W'(INC_STEP);

  logic [W-1:0] r_pc;
  logic         r_ovf;
  logic         r_unf;

  logic [W-1:0] w_pc_next;
  logic [W-1:0] w_pc_seq;
  logic [W-1:0] w_pc_rel;
  logic [W-1:0] w_top;
  logic         w_push;
  logic         w_pop;
  logic         w_empty;
  logic         w_drop;
  logic         w_unf_set;

  // Sums are modulo 2^W; a signed offset adds the same bits as an unsigned one.
  assign w_pc_seq = r_pc + STEP;
  assign w_pc_rel = r_pc + ia_in;

  always_comb begin
    w_pc_next = r_pc;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_unf_set = 1'b0;
    if (en) begin
      case (op_in)
        PC_INC:  w_pc_next = w_pc_seq;
        PC_REL:  w_pc_next = w_pc_rel;
        PC_ABS:  w_pc_next = ra_in;
        PC_CALL: begin
          w_pc_next = w_pc_rel;
          w_push    = 1'b1;
        end
        PC_RET: begin
          if (w_empty) begin
            w_pc_next = ra_in;
            w_unf_set = 1'b1;
          end else begin
            w_pc_next = w_top;
            w_pop     = 1'b1;
          end
        end
        default: w_pc_next = r_pc;
      endcase
    end
  end

  pc_ras_stack #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .pop       (w_pop),
    .push_data (w_pc_seq),
    .pop_data  (w_top),
    .count     (depth_out),
    .empty     (w_empty),
    .drop      (w_drop)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc  <= RESET_VEC;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_pc  <= w_pc_next;
      r_ovf <= r_ovf | w_drop;
      r_unf <= r_unf | w_unf_set;
    end
  end

  assign pc_out  = r_pc;
  assign ovf_out = r_ovf;
  assign unf_out = r_unf;

endmodule

// File: tb/tb_pc_ras.sv
// Self-checking bench for pc_ras: directed scenarios then random ops, compared
// against a queue-based reference model of the call/return behaviour.
module tb_pc_ras;
  import mycpu_pkg::*;

  localparam int          W   = 16;
  localparam int          D   = 4;
  localparam logic [15:0] RV  = 16'h0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [2:0]  op_in;
  logic [15:0] ia_in;
  logic [15:0] ra_in;
  logic [15:0] pc_out;
  logic [2:0]  depth_out;
  logic        ovf_out;
  logic        unf_out;

  int n_pass  = 0;
  int n_total = 0;

  logic [15:0] m_pc;
  logic [15:0] m_stack [$];
  logic        m_ovf;
  logic        m_unf;

  always #5 clk = ~clk;

  pc_ras #(
    .W         (W),
    .DEPTH     (D),
    .RESET_VEC (RV),
    .INC_STEP  (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .op_in     (op_in),
    .ia_in     (ia_in),
    .ra_in     (ra_in),
    .pc_out    (pc_out),
    .depth_out (depth_out),
    .ovf_out   (ovf_out),
    .unf_out   (unf_out)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, got, exp);
  endtask

  // Reference: a list of return addresses, newest at the back.
  task automatic model(input logic r, input logic e, input logic [2:0] op,
                       input logic [15:0] ia, input logic [15:0] ra);
    logic [15:0] ret;
    if (r) begin
      m_pc = RV;
      m_stack.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (e) begin
      case (op)
        3'd1: m_pc = m_pc + 16'd1;
        3'd2: m_pc = m_pc + ia;
        3'd3: m_pc = ra;
        3'd4: begin
          ret  = m_pc + 16'd1;
          m_pc = m_pc + ia;
          if (m_stack.size() < D) begin
            m_stack.push_back(ret);
          end else begin
`ifdef PC_RAS_WRAP_EN
            void'(m_stack.pop_front());
            m_stack.push_back(ret);
`else
            m_ovf = 1'b1;
`endif
          end
        end
        3'd5: begin
          if (m_stack.size() == 0) begin
            m_pc  = ra;
            m_unf = 1'b1;
          end else begin
            m_pc = m_stack.pop_back();
          end
        end
        default: m_pc = m_pc;
      endcase
    end
  endtask

  task automatic step(input logic r, input logic e, input logic [2:0] op,
                      input logic [15:0] ia, input logic [15:0] ra);
    rst = r; en = e; op_in = op; ia_in = ia; ra_in = ra;
    @(posedge clk);
    model(r, e, op, ia, ra);
    #1;
    $display("t=%0t rst=%0b en=%0b op=%0d ia=%h ra=%h -> pc=%h depth=%0d ovf=%0b unf=%0b",
             $time, r, e, op, ia, ra, pc_out, depth_out, ovf_out, unf_out);
    chk("pc", pc_out, m_pc);
    chk("depth", {13'd0, depth_out}, 16'(m_stack.size()));
    chk("ovf", {15'd0, ovf_out}, {15'd0, m_ovf});
    chk("unf", {15'd0, unf_out}, {15'd0, m_unf});
  endtask

  initial begin
    m_pc = '0; m_ovf = 1'b0; m_unf = 1'b0;

    // Reset and sequential increments
    step(1, 1, PC_INC, 0, 0);
    chk("rst_pc", pc_out, 16'h0100);
    step(0, 1, PC_INC, 0, 0);
    step(0, 1, PC_INC, 0, 0);
    step(0, 1, PC_INC, 0, 0);
    chk("inc3_pc", pc_out, 16'h0103);

    // Negative relative branch, absolute jump, wrap-around
    step(0, 1, PC_ABS, 0, 16'h0200);
    step(0, 1, PC_REL, 16'hFFF0, 0);
    chk("rel_neg_pc", pc_out, 16'h01F0);
    step(0, 1, PC_ABS, 0, 16'hFFFF);
    step(0, 1, PC_INC, 0, 0);
    chk("wrap_pc", pc_out, 16'h0000);

    // Nested call / return; return address is caller pc + 1
    step(0, 1, PC_ABS, 0, 16'h0300);
    step(0, 1, PC_CALL, 16'h0010, 0);
    step(0, 1, PC_CALL, 16'h0010, 0);
    chk("call2_pc", pc_out, 16'h0320);
    step(0, 1, PC_RET, 0, 0);
    chk("ret1_pc", pc_out, 16'h0311);
    step(0, 1, PC_RET, 0, 0);
    chk("ret2_pc", pc_out, 16'h0301);

    // Five calls into a four-deep stack, then four returns
    step(1, 1, PC_HOLD, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, PC_CALL, 16'h0001, 0);
    chk("call5_pc", pc_out, 16'h0105);
`ifdef PC_RAS_WRAP_EN
    chk("call5_ovf", {15'd0, ovf_out}, 16'd0);
    step(0, 1, PC_RET, 0, 0);
    chk("wret1", pc_out, 16'h0105);
    for (int i = 0; i < 3; i++) step(0, 1, PC_RET, 0, 0);
    chk("wret4", pc_out, 16'h0102);
`else
    chk("call5_ovf", {15'd0, ovf_out}, 16'd1);
    step(0, 1, PC_RET, 0, 0);
    chk("ret1_pc5", pc_out, 16'h0104);
    for (int i = 0; i < 3; i++) step(0, 1, PC_RET, 0, 0);
    chk("ret4_pc5", pc_out, 16'h0101);
`endif

    // Underflow falls back to ra_in, flag is sticky
    step(0, 1, PC_RET, 0, 16'h0ABC);
    chk("unf_pc", pc_out, 16'h0ABC);
    chk("unf_flag", {15'd0, unf_out}, 16'd1);
    for (int i = 0; i < 10; i++) step(0, 1, PC_INC, 0, 0);
    chk("unf_sticky", {15'd0, unf_out}, 16'd1);

    // Stall ignores the op completely, then reset overrides a call
    step(0, 1, PC_CALL, 16'h0020, 0);
    for (int i = 0; i < 3; i++) step(0, 0, PC_CALL, 16'h0040, 0);
    step(1, 1, PC_CALL, 16'h0040, 0);
    chk("rst_call_pc", pc_out, 16'h0100);
    chk("rst_call_depth", {13'd0, depth_out}, 16'd0);

    // Random traffic, biased toward calls/returns, with rare reset and stalls
    for (int i = 0; i < 400; i++) begin
      logic       r_rand;
      logic       e_rand;
      logic [2:0] o_rand;
      r_rand = ($urandom_range(0, 63) == 0);
      e_rand = ($urandom_range(0, 7) != 0);
      o_rand = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7))
                                           : 3'($urandom_range(4, 5));
      step(r_rand, e_rand, o_rand, 16'($urandom_range(0, 65535)),
           16'($urandom_range(0, 65535)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
